// File: rtl/id_wakeup_pkg.sv
// id_wakeup_pkg: shared sel encodings, shadow-slot layout and match helper
package id_wakeup_pkg;
    localparam int AW = 5;
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EXE = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_WB  = 2'd3;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] dst;
        logic          wen;
        logic          is_load;
    } slot_t;

    function automatic logic slot_match(slot_t s, logic [AW-1:0] src, logic used);
        return s.v & s.wen & (s.dst == src) & (src != '0) & used;
    endfunction
endpackage

// File: rtl/id_wakeup_match.sv
// id_wakeup_match: per-source bypass select (youngest producer wins) and load/busy stall
module wk_match
    import id_wakeup_pkg::*;
(
    input  logic [AW-1:0] src_i,
    input  logic          used_i,
    input  slot_t         exe_i,
    input  slot_t         mem_i,
    input  slot_t         wb_i,
    input  logic          res_ready_i,
    output logic [1:0]    sel_o,
    output logic          stall_o
);
    logic hit_exe, hit_mem, hit_wb;

    always_comb begin
        hit_exe = slot_match(exe_i, src_i, used_i);
        hit_mem = slot_match(mem_i, src_i, used_i);
        hit_wb  = slot_match(wb_i, src_i, used_i);
        sel_o   = hit_exe ? SEL_EXE : hit_mem ? SEL_MEM : hit_wb ? SEL_WB : SEL_RF;
        // value not produced yet: load data arrives in MEM, or EXE unit still busy
        stall_o = hit_exe & (exe_i.is_load | ~res_ready_i);
    end
endmodule

// File: rtl/id_wakeup.sv
// id_wakeup: ID-stage register interlock; shadows EXE/MEM/WB destinations to drive
// operand bypass selects and the ID stall.
module id_wakeup #(
    parameter int NREG  = 32,
    parameter int AW    = $clog2(NREG),
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_src1,
    input  logic [AW-1:0]    id_src2,
    input  logic             id_src1_used,
    input  logic             id_src2_used,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             id_fire,
    input  logic             exe_fire,
    input  logic             mem_fire,
    input  logic             wb_fire,
    input  logic             exe_res_ready,
    input  logic             flush,
    output logic             id_stall,
    output logic [1:0]       src1_sel,
    output logic [1:0]       src2_sel,
    output logic [CNT_W-1:0] stall_cnt
);
    import id_wakeup_pkg::*;

    slot_t exe_q, mem_q, wb_q, exe_d, mem_d, wb_d, id_slot;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic stall1, stall2;

    wk_match u_m1 (
        .src_i(id_src1), .used_i(id_src1_used), .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q),
        .res_ready_i(exe_res_ready), .sel_o(src1_sel), .stall_o(stall1)
    );

    wk_match u_m2 (
        .src_i(id_src2), .used_i(id_src2_used), .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q),
        .res_ready_i(exe_res_ready), .sel_o(src2_sel), .stall_o(stall2)
    );

    always_comb begin
        // writes to r0 are dropped at capture so r0 never matches
        id_slot     = '{v: 1'b1, dst: id_dst, wen: id_wen & (id_dst != '0), is_load: id_is_load};
        exe_d       = flush ? '0 : id_fire ? id_slot : exe_fire ? '0 : exe_q;
        mem_d       = exe_fire ? exe_q : mem_fire ? '0 : mem_q;
        wb_d        = mem_fire ? mem_q : wb_fire ? '0 : wb_q;
        id_stall    = id_valid & (stall1 | stall2);
        stall_cnt_d = (id_stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            exe_q       <= exe_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
endmodule
